mul_arb_256b_rr: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 256b SOS multiplier among N requesters (point add/double, inversion, etc.).

---
 rtl/sm2_mul_pkg.sv | 26 ++
 rtl/rr_arb_onehot.sv | 38 +++
 rtl/mul_arb_256b_rr.sv | 149 ++++++++++++++
 tb/tb_mul_arb_256b_rr.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm2_mul_pkg.sv
// Shared definitions for the SM2 multiplier arbiter: FSM encodings, datapath widths
// and an index-width helper.
package sm2_mul_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mul_arb_state_e;

    localparam int MUL_LAT = 17;
    localparam int WORD_W  = 256;
    localparam int PROD_W  = 512;

    // Bits needed to index v items; callers use v >= 2.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_onehot.sv
// Combinational round-robin pick: the first set request at or after ptr (wrapping)
// wins, reported as a one-hot grant plus its binary index.
module rr_arb_onehot
    import sm2_mul_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] id,
    output logic         any
);

    logic [W-1:0] idx_s;
    logic         found_s;

    // Scan from ptr upward, wrapping, and keep the first hit.
    always_comb begin
        gnt     = '0;
        id      = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = W'((int'(ptr) + i) % N);
            if (!found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                id         = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        any = found_s;
    end

endmodule

// File: rtl/mul_arb_256b_rr.sv
// Round-robin sequencer sharing one 256b SOS multiplier among N_REQ requesters.
// Optional watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arb_256b_rr
    import sm2_mul_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int TO_CYC = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_vld_i,
    input  logic [WORD_W*N_REQ-1:0] req_a_i,
    input  logic [WORD_W*N_REQ-1:0] req_b_i,
    output logic [N_REQ-1:0]        req_rdy_o,
    output logic [N_REQ-1:0]        rsp_vld_o,
    output logic [PROD_W-1:0]       rsp_r_o,
    output logic                    busy_o,
    output logic                    mul_vld_o,
    output logic [WORD_W-1:0]       mul_a_o,
    output logic [WORD_W-1:0]       mul_b_o,
    input  logic                    mul_fin_i,
    input  logic [PROD_W-1:0]       mul_r_i,
    output logic                    err_to_o
);

    localparam int ID_W = clog2(N_REQ);

    mul_arb_state_e    state_r, state_nxt;
    logic [ID_W-1:0]   ptr_r, ptr_nxt;
    logic [ID_W-1:0]   id_r, id_nxt;
    logic              mul_vld_nxt;
    logic [WORD_W-1:0] mul_a_nxt, mul_b_nxt;
    logic [PROD_W-1:0] rsp_r_nxt;
    logic [N_REQ-1:0]  rsp_vld_nxt;
    logic              err_to_nxt;

    logic [N_REQ-1:0]  gnt_s;
    logic [ID_W-1:0]   win_id_s;
    logic              win_any_s;
    logic              to_hit_s;

    rr_arb_onehot #(.N(N_REQ), .W(ID_W)) u_arb (
        .req (req_vld_i),
        .ptr (ptr_r),
        .gnt (gnt_s),
        .id  (win_id_s),
        .any (win_any_s)
    );

    assign req_rdy_o = (state_r == ST_IDLE) ? gnt_s : '0;
    assign busy_o    = (state_r != ST_IDLE);

`ifdef MUL_ARB_TIMEOUT_EN
    localparam logic [5:0] TO_LIM = 6'(TO_CYC - 1);
    logic [5:0] to_cnt_r;

    // Watchdog: idles at zero so it counts RUN cycles from zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= 6'd0;
        end else if (state_r != ST_RUN) begin
            to_cnt_r <= 6'd0;
        end else begin
            to_cnt_r <= to_cnt_r + 6'd1;
        end
    end

    assign to_hit_s = (state_r == ST_RUN) && (to_cnt_r == TO_LIM);
`else
    logic [5:0] to_lim_unused_s;
    assign to_lim_unused_s = 6'(TO_CYC);
    assign to_hit_s        = 1'b0;
`endif

    // Next-state and next-output logic for the grant/run sequence.
    always_comb begin
        state_nxt   = state_r;
        ptr_nxt     = ptr_r;
        id_nxt      = id_r;
        mul_vld_nxt = mul_vld_o;
        mul_a_nxt   = mul_a_o;
        mul_b_nxt   = mul_b_o;
        rsp_r_nxt   = rsp_r_o;
        rsp_vld_nxt = '0;
        err_to_nxt  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // mul_vld_o stays low for at least this cycle so the multiplier sees a fresh edge.
                if (win_any_s) begin
                    state_nxt   = ST_RUN;
                    mul_vld_nxt = 1'b1;
                    mul_a_nxt   = req_a_i[win_id_s*WORD_W +: WORD_W];
                    mul_b_nxt   = req_b_i[win_id_s*WORD_W +: WORD_W];
                    id_nxt      = win_id_s;
                    ptr_nxt     = (win_id_s == ID_W'(N_REQ - 1)) ? '0 : win_id_s + ID_W'(1);
                end else begin
                    mul_vld_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                // The product is only valid while fin is high, so capture it right here.
                if (mul_fin_i) begin
                    state_nxt          = ST_IDLE;
                    mul_vld_nxt        = 1'b0;
                    rsp_r_nxt          = mul_r_i;
                    rsp_vld_nxt[id_r]  = 1'b1;
                end else if (to_hit_s) begin
                    state_nxt          = ST_IDLE;
                    mul_vld_nxt        = 1'b0;
                    rsp_r_nxt          = '0;
                    rsp_vld_nxt[id_r]  = 1'b1;
                    err_to_nxt         = 1'b1;
                end else begin
                    mul_vld_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                mul_vld_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            id_r      <= '0;
            mul_vld_o <= 1'b0;
            mul_a_o   <= '0;
            mul_b_o   <= '0;
            rsp_r_o   <= '0;
            rsp_vld_o <= '0;
            err_to_o  <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            ptr_r     <= ptr_nxt;
            id_r      <= id_nxt;
            mul_vld_o <= mul_vld_nxt;
            mul_a_o   <= mul_a_nxt;
            mul_b_o   <= mul_b_nxt;
            rsp_r_o   <= rsp_r_nxt;
            rsp_vld_o <= rsp_vld_nxt;
            err_to_o  <= err_to_nxt;
        end
    end

endmodule

// File: tb/tb_mul_arb_256b_rr.sv
// Scoreboard bench for mul_arb_256b_rr with a behavioural 17-cycle multiplier model.
// Define MUL_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_mul_arb_256b_rr;
    import sm2_mul_pkg::*;

    localparam int N_REQ  = 4;
    localparam int TO_CYC = 32;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_vld;
    logic [WORD_W*N_REQ-1:0] req_a;
    logic [WORD_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]        req_rdy_o;
    logic [N_REQ-1:0]        rsp_vld_o;
    logic [PROD_W-1:0]       rsp_r_o;
    logic                    busy_o;
    logic                    mul_vld_o;
    logic [WORD_W-1:0]       mul_a_o;
    logic [WORD_W-1:0]       mul_b_o;
    logic                    mul_fin;
    logic [PROD_W-1:0]       mul_r;
    logic                    err_to_o;

    mul_arb_256b_rr #(.N_REQ(N_REQ), .TO_CYC(TO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld_i (req_vld),
        .req_a_i   (req_a),
        .req_b_i   (req_b),
        .req_rdy_o (req_rdy_o),
        .rsp_vld_o (rsp_vld_o),
        .rsp_r_o   (rsp_r_o),
        .busy_o    (busy_o),
        .mul_vld_o (mul_vld_o),
        .mul_a_o   (mul_a_o),
        .mul_b_o   (mul_b_o),
        .mul_fin_i (mul_fin),
        .mul_r_i   (mul_r),
        .err_to_o  (err_to_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [N_REQ-1:0] gnt; bit b2b; } gnt_t;
    typedef struct { int id; logic [PROD_W-1:0] r; int lat; bit err; } rsp_t;
    typedef struct { string name; int sel; logic [PROD_W-1:0] exp; } probe_t;

    gnt_t   gnt_q[$];
    rsp_t   rsp_q[$];
    probe_t probe_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [N_REQ-1:0] gnt_seen;
    bit hold_fin;
    bit stray;
    int mcnt;

    // Multiplier model: fin on the 18th cycle of a high mul_vld, R valid only then.
    always @(negedge clk) begin
        if (!rst_n || !mul_vld_o) mcnt = 0;
        else mcnt = mcnt + 1;
        if (mcnt == MUL_LAT + 1 && !hold_fin) begin
            mul_fin = 1'b1;
            mul_r   = {256'd0, mul_a_o} * {256'd0, mul_b_o};
        end else begin
            mul_fin = stray;
            mul_r   = {16{32'hDEADBEEF}};
        end
    end

    always @(negedge clk) gnt_seen = req_rdy_o;

    task automatic cmp(input string n, input logic [PROD_W-1:0] act, input logic [PROD_W-1:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    // Monitor: pops response, grant and probe expectations whenever the DUT presents them.
    int cyc_n = 0;
    int gnt_cyc = 0;
    int vld_run = 0;
    always @(negedge clk) begin
        rsp_t   e;
        gnt_t   g;
        probe_t p;
        logic [PROD_W-1:0] act;
        cyc_n = cyc_n + 1;
        if (!rst_n) vld_run = 0;
        else if (mul_vld_o) vld_run = vld_run + 1;
        if (rsp_vld_o != '0 || err_to_o) begin
            if (rsp_q.size() == 0) begin
                cmp("rsp_unexpected", PROD_W'(rsp_vld_o), '0);
            end else begin
                e = rsp_q.pop_front();
                cmp("rsp_vld", PROD_W'(rsp_vld_o), PROD_W'(1) << e.id);
                cmp("rsp_r", rsp_r_o, e.r);
                cmp("err_to", PROD_W'(err_to_o), PROD_W'(e.err));
                cmp("rsp_latency", PROD_W'(cyc_n - gnt_cyc), PROD_W'(e.lat));
                cmp("mul_vld_len", PROD_W'(vld_run), PROD_W'(e.lat - 1));
                vld_run = 0;
            end
        end
        if (req_rdy_o != '0) begin
            if (gnt_q.size() == 0) begin
                cmp("gnt_unexpected", PROD_W'(req_rdy_o), '0);
            end else begin
                g = gnt_q.pop_front();
                cmp("gnt", PROD_W'(req_rdy_o), PROD_W'(g.gnt));
                if (g.b2b) cmp("gnt_back_to_back", PROD_W'(rsp_vld_o != '0), PROD_W'(1));
                gnt_cyc = cyc_n;
            end
        end
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.sel)
                0: act = PROD_W'(busy_o);
                1: act = PROD_W'(mul_vld_o);
                2: act = PROD_W'(rsp_vld_o);
                3: act = rsp_r_o;
                4: act = PROD_W'(mul_a_o);
                5: act = PROD_W'(req_rdy_o);
                6: act = PROD_W'(err_to_o);
                7: act = PROD_W'(rsp_q.size() + gnt_q.size());
                8: act = PROD_W'(mul_b_o);
                default: act = 'x;
            endcase
            cmp(p.name, act, p.exp);
        end
    end

    task automatic probe(input string n, input int s, input logic [PROD_W-1:0] e);
        probe_t p;
        p.name = n; p.sel = s; p.exp = e;
        probe_q.push_back(p);
    endtask

    task automatic exp_gnt(input logic [N_REQ-1:0] g, input bit b2b);
        gnt_t x;
        x.gnt = g; x.b2b = b2b;
        gnt_q.push_back(x);
    endtask

    task automatic exp_rsp(input int id, input logic [PROD_W-1:0] r, input int lat, input bit err);
        rsp_t x;
        x.id = id; x.r = r; x.lat = lat; x.err = err;
        rsp_q.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        req_vld = req_vld & ~gnt_seen;
    endtask

    task automatic set_req(input int k, input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
        req_a[k*WORD_W +: WORD_W] = a;
        req_b[k*WORD_W +: WORD_W] = b;
        req_vld[k] = 1'b1;
    endtask

    task automatic wait_gnt(input int k, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            cyc();
            if (gnt_seen[k]) break;
        end
        if (i == budget) probe("wait_gnt_expired", 5, PROD_W'(1) << k);
    endtask

    task automatic drain(input string n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rsp_q.size() == 0 && gnt_q.size() == 0) break;
            cyc();
        end
        probe(n, 7, '0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        logic [WORD_W-1:0] ones;
        logic [WORD_W-1:0] big_a, big_b;
        logic [PROD_W-1:0] big_r;
        rst_n = 1'b0; req_vld = '0; req_a = '0; req_b = '0;
        hold_fin = 1'b0; stray = 1'b0;
        mul_fin = 1'b0; mul_r = '0;
        cyc(); cyc();
        probe("rst_busy", 0, '0);
        probe("rst_mul_vld", 1, '0);
        probe("rst_rsp_vld", 2, '0);
        probe("rst_rsp_r", 3, '0);
        probe("rst_mul_a", 4, '0);
        probe("rst_err_to", 6, '0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // All four requesters at once from rr_ptr=0, then requester 0 again.
        exp_gnt(4'b0001, 1'b0); exp_rsp(0, 512'd77, 19, 1'b0);
        exp_gnt(4'b0010, 1'b1); exp_rsp(1, 512'd221, 19, 1'b0);
        exp_gnt(4'b0100, 1'b1); exp_rsp(2, 512'd437, 19, 1'b0);
        exp_gnt(4'b1000, 1'b1); exp_rsp(3, 512'd899, 19, 1'b0);
        exp_gnt(4'b0001, 1'b1); exp_rsp(0, 512'd20000, 19, 1'b0);
        set_req(0, 256'd7, 256'd11);
        set_req(1, 256'd13, 256'd17);
        set_req(2, 256'd19, 256'd23);
        set_req(3, 256'd29, 256'd31);
        wait_gnt(3, 200);
        set_req(0, 256'd100, 256'd200);
        drain("drain_rr4", 200);

        // Single request 3*5, grant visible in the same cycle.
        exp_gnt(4'b0001, 1'b0); exp_rsp(0, 512'd15, 19, 1'b0);
        set_req(0, 256'd3, 256'd5);
        probe("t1_rdy_same_cycle", 5, 512'b0001);
        wait_gnt(0, 10);
        probe("t1_mul_vld", 1, 512'd1);
        probe("t1_busy", 0, 512'd1);
        probe("t1_mul_a", 4, 512'd3);
        probe("t1_mul_b", 8, 512'd5);
        drain("drain_t1", 100);

        // Full carry chain: (2^256-1)^2 = 2^512 - 2^257 + 1.
        ones = {256{1'b1}};
        exp_gnt(4'b0001, 1'b0);
        exp_rsp(0, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}, 19, 1'b0);
        set_req(0, ones, ones);
        drain("drain_allones", 100);

        // Request 2 arrives while 0 runs; waits until the IDLE cycle after the response.
        exp_gnt(4'b0001, 1'b0); exp_rsp(0, 512'd42, 19, 1'b0);
        exp_gnt(4'b0100, 1'b1); exp_rsp(2, 512'd1000000, 19, 1'b0);
        set_req(0, 256'd6, 256'd7);
        wait_gnt(0, 10);
        repeat (3) cyc();
        set_req(2, 256'd1000, 256'd1000);
        probe("t4_rdy_in_run", 5, '0);
        probe("t4_mul_a_hold", 4, 512'd6);
        repeat (6) cyc();
        probe("t4_mul_a_hold2", 4, 512'd6);
        probe("t4_mul_b_hold", 8, 512'd7);
        drain("drain_t4", 100);

        // rr_ptr now 3: requests 1 and 2 together -> 1 wins by wrap, then 2.
        exp_gnt(4'b0010, 1'b0); exp_rsp(1, 512'd81, 19, 1'b0);
        exp_gnt(4'b0100, 1'b1); exp_rsp(2, 512'd144, 19, 1'b0);
        set_req(1, 256'd9, 256'd9);
        set_req(2, 256'd12, 256'd12);
        drain("drain_tie", 100);

        // Stray fin while IDLE: no capture, no strobe.
        stray = 1'b1;
        cyc();
        stray = 1'b0;
        cyc();
        probe("stray_rsp_r", 3, 512'd144);
        probe("stray_rsp_vld", 2, '0);
        probe("stray_busy", 0, '0);
        cyc();

        // Reset ten cycles into a job: outputs clear at once, no response.
        exp_gnt(4'b1000, 1'b0);
        set_req(3, 256'd77, 256'd88);
        wait_gnt(3, 10);
        repeat (9) cyc();
        rst_n = 1'b0;
        probe("rst_mid_mul_vld", 1, '0);
        probe("rst_mid_busy", 0, '0);
        probe("rst_mid_rsp_vld", 2, '0);
        probe("rst_mid_rsp_r", 3, '0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        big_a = '0; big_a[200] = 1'b1;
        big_b = '0; big_b[100] = 1'b1;
        big_r = '0; big_r[300] = 1'b1;
        exp_gnt(4'b0010, 1'b0); exp_rsp(1, big_r, 19, 1'b0);
        set_req(1, big_a, big_b);
        drain("drain_after_rst", 100);

`ifdef MUL_ARB_TIMEOUT_EN
        // Multiplier never finishes: watchdog returns zero with err_to.
        hold_fin = 1'b1;
        exp_gnt(4'b0001, 1'b0); exp_rsp(0, '0, TO_CYC + 1, 1'b1);
        set_req(0, 256'd5, 256'd5);
        drain("drain_timeout", 100);
        hold_fin = 1'b0;
        stray = 1'b1;
        cyc();
        stray = 1'b0;
        cyc();
        probe("late_fin_rsp_vld", 2, '0);
        probe("late_fin_rsp_r", 3, '0);
        probe("late_fin_err", 6, '0);
        cyc();
`endif

        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
